// File: rtl/dsp_mac_chain.sv
// Multi-lane multiply-accumulate: operand regs, lane products, lane sum, accumulate/output.
// Optional clamping of the accumulator on overflow when DSP_MAC_SATURATE_EN is defined.
module dsp_mac_chain #(
   parameter int LANES  = 4,
   parameter int A_W    = 16,
   parameter int B_W    = 16,
   parameter int ACC_W  = 48,
   parameter int CNT_W  = 16,
   parameter bit SIGNED = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*A_W-1:0]   in_a,
   input  logic [LANES*B_W-1:0]   in_b,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_W-1:0]       out_p,
   output logic [CNT_W-1:0]       out_beats,
   output logic                   out_ovf
);

   localparam int P_W = A_W + B_W;
   localparam int S_W = P_W + $clog2(LANES);

   logic                        stall;
   logic                        v1_q, l1_q, v2_q, l2_q, v3_q, l3_q;
   logic [LANES*A_W-1:0]        a1_q;
   logic [LANES*B_W-1:0]        b1_q;
   logic [LANES-1:0][P_W-1:0]   prod_d, prod_q;
   logic [S_W-1:0]              sum_d, sum_q;
   logic [ACC_W-1:0]            acc_q, acc_d, sum_ext, acc_next;
   logic [ACC_W:0]              add_full;
   logic                        beat_ovf;
   logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_inc;
   logic                        ovf_q, ovf_d;
   logic                        out_valid_q, out_valid_d;
   logic [ACC_W-1:0]            out_p_q, out_p_d;
   logic [CNT_W-1:0]            out_beats_q, out_beats_d;
   logic                        out_ovf_q, out_ovf_d;

   // A held result freezes the whole pipeline; ready never depends on in_valid.
   assign stall    = out_valid_q && !out_ready;
   assign in_ready = !stall;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [P_W-1:0] a_ext, b_ext;
         if (SIGNED) begin : g_sext
            assign a_ext = P_W'($signed(a1_q[gi*A_W +: A_W]));
            assign b_ext = P_W'($signed(b1_q[gi*B_W +: B_W]));
         end else begin : g_zext
            assign a_ext = P_W'(a1_q[gi*A_W +: A_W]);
            assign b_ext = P_W'(b1_q[gi*B_W +: B_W]);
         end
         assign prod_d[gi] = a_ext * b_ext;
      end
   endgenerate

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < LANES; i++) begin
         if (SIGNED) sum_d = sum_d + S_W'($signed(prod_q[i]));
         else        sum_d = sum_d + S_W'(prod_q[i]);
      end
   end

   generate
      if (SIGNED) begin : g_sum_sext
         assign sum_ext = ACC_W'($signed(sum_q));
      end else begin : g_sum_zext
         assign sum_ext = ACC_W'(sum_q);
      end
   endgenerate

   assign add_full = {1'b0, acc_q} + {1'b0, sum_ext};
   assign beat_ovf = SIGNED ? ((acc_q[ACC_W-1] == sum_ext[ACC_W-1]) &&
                               (add_full[ACC_W-1] != acc_q[ACC_W-1]))
                            : add_full[ACC_W];
   assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef DSP_MAC_SATURATE_EN
   logic [ACC_W-1:0] clamp_val;
   // Signed overflow direction follows the accumulator sign (both addends agree).
   assign clamp_val = SIGNED ? {acc_q[ACC_W-1], {(ACC_W-1){~acc_q[ACC_W-1]}}} : '1;
   assign acc_next  = beat_ovf ? clamp_val : add_full[ACC_W-1:0];
`else
   assign acc_next  = add_full[ACC_W-1:0];
`endif

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_p_d     = out_p_q;
      out_beats_d = out_beats_q;
      out_ovf_d   = out_ovf_q;
      if (!stall) begin
         out_valid_d = 1'b0;
         if (v3_q && l3_q) begin
            out_p_d     = acc_next;
            out_beats_d = cnt_inc;
            out_ovf_d   = ovf_q | beat_ovf;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
         end else if (v3_q) begin
            acc_d = acc_next;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | beat_ovf;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         v3_q        <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_p_q     <= '0;
         out_beats_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         if (!stall) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
         end
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_p_q     <= out_p_d;
         out_beats_q <= out_beats_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   // Datapath registers need no reset; their valid bits qualify them.
   always_ff @(posedge clk) begin
      if (!stall) begin
         a1_q   <= in_a;
         b1_q   <= in_b;
         l1_q   <= in_last;
         prod_q <= prod_d;
         l2_q   <= l1_q;
         sum_q  <= sum_d;
         l3_q   <= l2_q;
      end
   end

   assign out_valid = out_valid_q;
   assign out_p     = out_p_q;
   assign out_beats = out_beats_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dsp_mac_chain.sv
// Bench for dsp_mac_chain: directed + randomized vectors against a dot-product model,
// plus a 34-bit unsigned instance for overflow (wrap or clamp under DSP_MAC_SATURATE_EN).
module tb_dsp_mac_chain;

   typedef struct {
      longint p;
      int     beats;
      bit     ovf;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
   logic [63:0] in_a, in_b;
   logic [47:0] out_p;
   logic [15:0] out_beats;

   logic        in_valid2, in_ready2, in_last2, out_valid2, out_ovf2;
   logic        out_ready2;
   logic [63:0] in_a2, in_b2;
   logic [33:0] out_p2;
   logic [15:0] out_beats2;

   int     n_checks = 0;
   int     n_pass   = 0;
   int     n_fail   = 0;
   res_t   exp_q[$];
   longint acc_m;
   int     cnt_m;
   bit     ovf_m;
   bit     rand_ready = 1'b0;

   always #5 clk = ~clk;

   dsp_mac_chain #(.LANES(4), .A_W(16), .B_W(16), .ACC_W(48), .CNT_W(16), .SIGNED(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
      .out_beats(out_beats), .out_ovf(out_ovf)
   );

   dsp_mac_chain #(.LANES(4), .A_W(16), .B_W(16), .ACC_W(34), .CNT_W(16), .SIGNED(1'b0)) u_ovf (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2), .in_last(in_last2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_p(out_p2),
      .out_beats(out_beats2), .out_ovf(out_ovf2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic longint beat_sum(input logic [63:0] a, input logic [63:0] b, input bit sgn);
      longint s = 0;
      for (int i = 0; i < 4; i++) begin
         logic [15:0] x, y;
         x = a[i*16 +: 16];
         y = b[i*16 +: 16];
         if (sgn) s += longint'($signed(x)) * longint'($signed(y));
         else     s += longint'(x) * longint'(y);
      end
      return s;
   endfunction

   // Mathematical accumulate into a w-bit register: overflow if the true sum leaves the range.
   task automatic acc_step(input longint acc, input longint s, input int w, input bit sgn,
                           output longint nacc, output bit ov);
      longint t, lo, hi, m, r;
      t  = acc + s;
      m  = longint'(1) << w;
      lo = sgn ? -(m >>> 1) : 0;
      hi = sgn ? (m >>> 1) - 1 : m - 1;
      ov = (t < lo) || (t > hi);
`ifdef DSP_MAC_SATURATE_EN
      nacc = (t < lo) ? lo : (t > hi) ? hi : t;
`else
      r = t % m;
      if (r < 0) r += m;
      if (sgn && r > hi) r -= m;
      nacc = r;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input bit last);
      int     guard = 0;
      longint nacc;
      bit     ov;
      in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            tick();
            break;
         end
         tick();
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         guard++;
         if (guard > 300) begin
            check("in_ready_timeout", {63'b0, in_ready}, 64'd1);
            break;
         end
      end
      in_valid = 1'b0;
      acc_step(acc_m, beat_sum(a, b, 1'b1), 48, 1'b1, nacc, ov);
      acc_m = nacc;
      ovf_m = ovf_m | ov;
      cnt_m++;
      if (last) begin
         exp_q.push_back('{p: acc_m, beats: cnt_m, ovf: ovf_m});
         acc_m = 0; cnt_m = 0; ovf_m = 1'b0;
      end
   endtask

   task automatic drain();
      int g = 0;
      out_ready = 1'b1;
      while (exp_q.size() > 0 && g < 300) begin
         tick();
         g++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Result monitor: a handshake seen at the falling edge completes on the next rising edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", {63'b0, out_valid}, 64'd0);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            check("out_p", 64'(out_p), 64'(e.p[47:0]));
            check("out_beats", 64'(out_beats), 64'(e.beats));
            check("out_ovf", {63'b0, out_ovf}, {63'b0, e.ovf});
            $display("result p=%0d beats=%0d ovf=%0b (expected p=%0d beats=%0d ovf=%0b)",
                     $signed(out_p), out_beats, out_ovf, e.p, e.beats, e.ovf);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a, b, ones;
      longint      acc2, nacc;
      bit          ov2, ov;
      int          g;

      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
      in_valid2 = 1'b0; in_last2 = 1'b0; in_a2 = '0; in_b2 = '0; out_ready2 = 1'b1;
      acc_m = 0; cnt_m = 0; ovf_m = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_out_valid", {63'b0, out_valid}, 64'd0);
      check("rst_out_p", 64'(out_p), 64'd0);
      check("rst_out_beats", 64'(out_beats), 64'd0);
      check("rst_out_ovf", {63'b0, out_ovf}, 64'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_reset", {63'b0, in_ready}, 64'd1);
      tick();

      // Single beat {1,2,3,4}.{5,6,7,8}; out_valid must rise on the 4th edge.
      a = {16'd4, 16'd3, 16'd2, 16'd1};
      b = {16'd8, 16'd7, 16'd6, 16'd5};
      send_beat(a, b, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) @(posedge clk);
         @(negedge clk);
         check("latency_out_valid", {63'b0, out_valid}, {63'b0, (k == 4)});
         if (k == 4) check("dot_70", 64'(out_p), 64'd70);
      end
      tick();

      // Three beats of -3*2 per lane, then an immediate single beat of ones.
      a = {4{16'hFFFD}};
      b = {4{16'd2}};
      send_beat(a, b, 1'b0);
      send_beat(a, b, 1'b0);
      send_beat(a, b, 1'b1);
      a = {4{16'd1}};
      send_beat(a, a, 1'b1);
      drain();

      // Stall: first result held while three more beats sit in the pipeline.
      out_ready = 1'b0;
      for (int v = 0; v < 4; v++) send_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_in_ready", {63'b0, in_ready}, 64'd0);
         check("stall_out_p", 64'(out_p), 64'(exp_q[0].p[47:0]));
         tick();
      end
      drain();

      // Randomized vectors with random backpressure and gaps.
      rand_ready = 1'b1;
      for (int v = 0; v < 15; v++) begin
         int nb = $urandom_range(1, 4);
         for (int j = 0; j < nb; j++) begin
            send_beat({$urandom, $urandom}, {$urandom, $urandom}, (j == nb - 1));
            repeat ($urandom_range(0, 2)) begin
               out_ready = 1'($urandom_range(0, 1));
               tick();
            end
         end
      end
      rand_ready = 1'b0;
      drain();

      // Reset mid-vector after two beats; the partial vector is discarded.
      send_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      send_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      rst_n = 1'b0;
      acc_m = 0; cnt_m = 0; ovf_m = 1'b0;
      tick();
      @(negedge clk);
      check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
      check("midrst_out_p", 64'(out_p), 64'd0);
      check("midrst_out_beats", 64'(out_beats), 64'd0);
      check("midrst_out_ovf", {63'b0, out_ovf}, 64'd0);
      tick();
      rst_n = 1'b1;
      send_beat(64'd1, 64'd1, 1'b1);
      drain();

      // Unsigned 34-bit accumulator overflowed by two all-ones beats.
      ones = '1;
      acc2 = 0; ov2 = 1'b0;
      for (int j = 0; j < 2; j++) begin
         in_a2 = ones; in_b2 = ones; in_last2 = (j == 1); in_valid2 = 1'b1;
         @(negedge clk);
         check("ovf_in_ready", {63'b0, in_ready2}, 64'd1);
         tick();
         acc_step(acc2, beat_sum(ones, ones, 1'b0), 34, 1'b0, nacc, ov);
         acc2 = nacc;
         ov2  = ov2 | ov;
      end
      in_valid2 = 1'b0;
      g = 0;
      do begin
         @(negedge clk);
         if (out_valid2) break;
         tick();
         g++;
      end while (g < 20);
      check("ovf_out_valid", {63'b0, out_valid2}, 64'd1);
      check("ovf_out_p", 64'(out_p2), 64'(acc2[33:0]));
      check("ovf_out_beats", 64'(out_beats2), 64'd2);
      check("ovf_out_ovf", {63'b0, out_ovf2}, {63'b0, ov2});
      $display("overflow p=%0d beats=%0d ovf=%0b (expected p=%0d ovf=%0b)",
               out_p2, out_beats2, out_ovf2, acc2, ov2);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
